marquee_uart_rx: RTL and testbench

- Receive end for the 16-segment scrolling marquee: accepts ASCII text over an 8N1 UART line instead of a hard-coded message.
- Each received character is encoded to a 16-segment active-low glyph and shifted into the 4-character display chain from the right (d → c → b → a).
- Sits between the board's serial RX pin and the LEDa..LEDd segment outputs, clocked from the on-chip 12.09 MHz oscillator.

---
 rtl/marquee_uart_rx.sv | 152 +++++++++++++++
 tb/tb_marquee_uart_rx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/marquee_uart_rx.sv
// 8N1 UART receiver feeding a 4-character 16-segment scrolling marquee.
// Each good byte is font-encoded (active-low) and shifted in on the right; CR/LF blanks the display.
module marquee_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 1259,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic [15:0] LEDa,
  output logic [15:0] LEDb,
  output logic [15:0] LEDc,
  output logic [15:0] LEDd
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  localparam logic [15:0] BIT_RELOAD  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_RELOAD = 16'(HALF_BIT - 1);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  sh, sh_n;
  logic        rx_meta, rxs;
  logic        commit, ferr;

  function automatic logic [15:0] font(input logic [7:0] ch);
    case (ch)
      8'h53:   font = 16'h223F;
      8'h61:   font = 16'hF17D;
      8'h6E:   font = 16'hFD7D;
      8'h74:   font = 16'hFC7F;
      8'h77:   font = 16'hEDFA;
      8'h73:   font = 16'h767D;
      8'h68:   font = 16'hFC7D;
      8'h65:   font = 16'hF57E;
      default: font = 16'hFFFF;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
    end
  end

  // Each timed state counts cnt down to zero; the sample is taken in the cycle where cnt == 0.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    commit  = 1'b0;
    ferr    = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          cnt_n   = HALF_RELOAD;
          state_n = START;
        end
      end
      START: begin
        if (cnt != '0) begin
          cnt_n = cnt - 16'd1;
        end else if (!rxs) begin
          cnt_n   = BIT_RELOAD;
          idx_n   = '0;
          state_n = DATA;
        end else begin
          state_n = IDLE;
        end
      end
      DATA: begin
        if (cnt != '0) begin
          cnt_n = cnt - 16'd1;
        end else begin
          sh_n  = {rxs, sh[7:1]};
          cnt_n = BIT_RELOAD;
          if (idx == 3'd7) state_n = STOP;
          else             idx_n   = idx + 3'd1;
        end
      end
      STOP: begin
        if (cnt != '0) begin
          cnt_n = cnt - 16'd1;
        end else if (rxs) begin
          commit  = 1'b1;
          state_n = IDLE;
        end else begin
          ferr    = 1'b1;
          state_n = BREAK;
        end
      end
      BREAK: begin
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      LEDa      <= '1;
      LEDb      <= '1;
      LEDc      <= '1;
      LEDd      <= '1;
    end else begin
      rx_valid  <= commit;
      frame_err <= ferr;
      if (commit) begin
        rx_data <= sh;
        if (sh == 8'h0D || sh == 8'h0A) begin
          LEDa <= '1;
          LEDb <= '1;
          LEDc <= '1;
          LEDd <= '1;
        end else begin
          LEDa <= LEDb;
          LEDb <= LEDc;
          LEDc <= LEDd;
          LEDd <= font(sh);
        end
      end
    end
  end

endmodule

// File: tb/tb_marquee_uart_rx.sv
// Directed bench for marquee_uart_rx: a queue of expected frames plus a 4-slot display model
// is checked every cycle, with literal display snapshots taken between scenarios.
module tb_marquee_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  // start edge driven after posedge t: 2 sync flops, IDLE detect, half bit, 8 data + stop bits
  localparam int LAT  = 3 + HALF + 9 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid, frame_err;
  logic [15:0] LEDa, LEDb, LEDc, LEDd;

  marquee_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .LEDa(LEDa), .LEDb(LEDb), .LEDc(LEDc), .LEDd(LEDd)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] b;
    int         t;
  } exp_t;

  typedef struct {
    string       nm;
    logic [15:0] a, b, c, d;
    logic [7:0]  data;
  } pin_t;

  exp_t exp_q[$];
  pin_t pin_q[$];
  int   cyc  = 0;
  bit   done = 1'b0;

  int          nvec = 0;
  int          nerr = 0;
  logic [15:0] m_led[4];
  logic [7:0]  m_data;
  bit          prev_v, prev_e;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] glyph(input logic [7:0] ch);
    logic [7:0]  chars[9]  = '{8'h53, 8'h61, 8'h6E, 8'h74, 8'h77, 8'h73, 8'h68, 8'h65, 8'h20};
    logic [15:0] shapes[9] = '{16'h223F, 16'hF17D, 16'hFD7D, 16'hFC7F, 16'hEDFA,
                               16'h767D, 16'hFC7D, 16'hF57E, 16'hFFFF};
    glyph = 16'hFFFF;
    for (int i = 0; i < 9; i++)
      if (chars[i] == ch) glyph = shapes[i];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    pin_t p;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_led[i] = 16'hFFFF;
      m_data = 8'h00;
      prev_v = 1'b0;
      prev_e = 1'b0;
    end else begin
      if (rx_valid) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nerr++;
          $display("FAIL unexpected_rx_valid: rx_data=%h at cycle %0d, no frame pending", rx_data, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.is_err || rx_data !== e.b || cyc != e.t + LAT) begin
            nerr++;
            $display("FAIL commit: got data=%h cycle=%0d, want err=%0d data=%h cycle=%0d",
                     rx_data, cyc, e.is_err, e.b, e.t + LAT);
          end
          if (!e.is_err) begin
            m_data = e.b;
            if (e.b == 8'h0D || e.b == 8'h0A) begin
              for (int i = 0; i < 4; i++) m_led[i] = 16'hFFFF;
            end else begin
              m_led[0] = m_led[1];
              m_led[1] = m_led[2];
              m_led[2] = m_led[3];
              m_led[3] = glyph(e.b);
            end
          end
        end
      end
      if (frame_err) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nerr++;
          $display("FAIL unexpected_frame_err at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          if (!e.is_err || cyc != e.t + LAT) begin
            nerr++;
            $display("FAIL frame_err: got cycle=%0d, want err=%0d cycle=%0d", cyc, e.is_err, e.t + LAT);
          end
        end
      end
      nvec++;
      if ((rx_valid && frame_err) || (rx_valid && prev_v) || (frame_err && prev_e) ||
          (rx_valid && prev_e) || (frame_err && prev_v)) begin
        nerr++;
        $display("FAIL pulse_rules: valid=%b err=%b prev_valid=%b prev_err=%b, want isolated single pulses",
                 rx_valid, frame_err, prev_v, prev_e);
      end
      prev_v = rx_valid;
      prev_e = frame_err;
      nvec++;
      if ({LEDa, LEDb, LEDc, LEDd} !== {m_led[0], m_led[1], m_led[2], m_led[3]} || rx_data !== m_data) begin
        nerr++;
        $display("FAIL display: got %h %h %h %h data=%h, want %h %h %h %h data=%h",
                 LEDa, LEDb, LEDc, LEDd, rx_data, m_led[0], m_led[1], m_led[2], m_led[3], m_data);
      end
    end
    while (pin_q.size() > 0) begin
      p = pin_q.pop_front();
      nvec++;
      if ({LEDa, LEDb, LEDc, LEDd} !== {p.a, p.b, p.c, p.d} || rx_data !== p.data ||
          rx_valid !== 1'b0 || frame_err !== 1'b0 ||
          {m_led[0], m_led[1], m_led[2], m_led[3]} !== {p.a, p.b, p.c, p.d} || m_data !== p.data) begin
        nerr++;
        $display("FAIL %s: dut %h %h %h %h data=%h v=%b e=%b model %h %h %h %h, want %h %h %h %h data=%h v=0 e=0",
                 p.nm, LEDa, LEDb, LEDc, LEDd, rx_data, rx_valid, frame_err,
                 m_led[0], m_led[1], m_led[2], m_led[3], p.a, p.b, p.c, p.d, p.data);
      end
    end
    if (done) begin
      nvec++;
      if (exp_q.size() != 0) begin
        nerr++;
        $display("FAIL pending_frames: %0d expected events never seen, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit stop_bit);
    exp_t e;
    @(negedge clk);
    rx = 1'b0;
    e.is_err = !stop_bit;
    e.b      = stop_bit ? b : 8'h00;
    e.t      = cyc;
    exp_q.push_back(e);
    idle(CPB - 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx = b[i];
      idle(CPB - 1);
    end
    @(negedge clk);
    rx = stop_bit;
    idle(CPB - 1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i], 1'b1);
  endtask

  task automatic pin(input string nm, input logic [15:0] a, b, c, d, input logic [7:0] data);
    pin_t p;
    p.nm = nm; p.a = a; p.b = b; p.c = c; p.d = d; p.data = data;
    pin_q.push_back(p);
    idle(2);
  endtask

  initial begin
    logic [7:0] part;
    idle(3);
    pin("reset_state", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'h00);
    rst = 1'b0;
    idle(5);

    send(8'h53, 1'b1);
    idle(4);
    pin("single_S", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h223F, 8'h53);

    send_str("Santa");
    idle(4);
    pin("scroll_Santa", 16'hF17D, 16'hFD7D, 16'hFC7F, 16'hF17D, 8'h61);

    @(negedge clk);
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(3 * CPB);
    pin("after_glitch", 16'hF17D, 16'hFD7D, 16'hFC7F, 16'hF17D, 8'h61);
    send(8'h65, 1'b1);
    idle(4);
    pin("glitch_then_e", 16'hFD7D, 16'hFC7F, 16'hF17D, 16'hF57E, 8'h65);

    send(8'h41, 1'b0);
    idle(40 * CPB);
    rx = 1'b1;
    idle(2 * CPB);
    pin("after_break", 16'hFD7D, 16'hFC7F, 16'hF17D, 16'hF57E, 8'h65);
    send(8'h68, 1'b1);
    idle(4);
    pin("break_then_h", 16'hFC7F, 16'hF17D, 16'hF57E, 16'hFC7D, 8'h68);

    send_str("wash");
    idle(4);
    pin("wash", 16'hEDFA, 16'hF17D, 16'h767D, 16'hFC7D, 8'h68);
    send(8'h5A, 1'b1);
    idle(4);
    pin("unknown_Z", 16'hF17D, 16'h767D, 16'hFC7D, 16'hFFFF, 8'h5A);
    send(8'h0D, 1'b1);
    idle(4);
    pin("carriage_return", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'h0D);
    send(8'h6E, 1'b1);
    send(8'h0A, 1'b1);
    idle(4);
    pin("line_feed", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'h0A);

    send_str("ts");
    idle(4);
    part = 8'h73;
    @(negedge clk);
    rx = 1'b0;
    idle(CPB - 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rx = part[i];
      idle(CPB - 1);
    end
    @(negedge clk);
    rx = part[3];
    idle(HALF);
    @(posedge clk);
    #2;
    rst = 1'b1;
    rx  = 1'b1;
    pin("reset_mid_frame", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'h00);
    idle(3);
    rst = 1'b0;
    idle(5);
    send(8'h73, 1'b1);
    idle(4);
    pin("after_reset_s", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h767D, 8'h73);

    idle(10);
    done = 1'b1;
    idle(5);
    $display("FAIL summary_not_reached: compare process did not finish, want summary");
    $fatal(1);
  end

endmodule
